// File: rtl/video_dc_restore_if.sv
// rtl/video_dc_restore_if.sv - raw ADC sample stream in, clamped stream and clamp status out
interface video_dc_restore_if;
    logic        sample_valid;
    logic [11:0] adc_data;
    logic        adc_otr;
    logic [11:0] data_out;
    logic        data_valid;
    logic [11:0] blank_level;
    logic [11:0] tip_level;
    logic [11:0] sync_amp;
    logic        clamp_locked;
    logic        hsync_seen;

    modport master (
        output sample_valid, adc_data, adc_otr,
        input  data_out, data_valid, blank_level, tip_level, sync_amp, clamp_locked, hsync_seen
    );

    modport slave (
        input  sample_valid, adc_data, adc_otr,
        output data_out, data_valid, blank_level, tip_level, sync_amp, clamp_locked, hsync_seen
    );
endinterface

// File: rtl/video_dc_restore.sv
// rtl/video_dc_restore.sv - black-level clamp: finds h-sync tips, averages the back porch,
// and offsets every sample so the filtered blanking level lands on BLANK_TARGET.
module video_dc_restore #(
    parameter logic [11:0] SYNC_LEVEL   = 12'd1024,
    parameter int          MIN_SYNC     = 100,
    parameter int          MAX_SYNC     = 400,
    parameter int          TIP_LEN_LOG2 = 6,
    parameter int          BP_DELAY     = 20,
    parameter int          BP_LEN_LOG2  = 6,
    parameter int          IIR_SHIFT    = 2,
    parameter logic [11:0] BLANK_TARGET = 12'd1200,
    parameter int          LOCK_LINES   = 8,
    parameter int          LINE_TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              rst_n,
    video_dc_restore_if.slave vif
);
    localparam int LEN_LOG2 = (TIP_LEN_LOG2 > BP_LEN_LOG2) ? TIP_LEN_LOG2 : BP_LEN_LOG2;
    localparam int ACC_W    = 12 + LEN_LOG2;
    localparam int CNT_W    = LEN_LOG2 + 1;
    localparam int RUN_W    = $clog2(MAX_SYNC + 2);
    localparam int WAIT_W   = $clog2(BP_DELAY + 1);
    localparam int LOCK_W   = $clog2(LOCK_LINES + 1);
    localparam int TMO_W    = $clog2(LINE_TIMEOUT + 1);

    localparam logic [RUN_W-1:0]  RUN_MIN   = RUN_W'(MIN_SYNC);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_SYNC);
    localparam logic [CNT_W-1:0]  TIP_N     = CNT_W'(2 ** TIP_LEN_LOG2);
    localparam logic [CNT_W-1:0]  BP_LAST   = CNT_W'(2 ** BP_LEN_LOG2 - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BP_DELAY - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_LINES);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(LINE_TIMEOUT);

    typedef enum logic [1:0] {SEEK, TIP, WAIT, PORCH} state_t;

    state_t             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [LOCK_W-1:0]  lock_q, lock_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [11:0]        tip_q, tip_d;
    logic [11:0]        blank_q, blank_d;
    logic [11:0]        amp_q, amp_d;
    logic [11:0]        dout_q, dout_d;
    logic               dv_q, dv_d;
    logic               hs_q, hs_d;

    logic               below;
    logic [ACC_W-1:0]   acc_sum;
    logic [11:0]        avg;
    logic signed [13:0] pix, diff, new_blank, amp_diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEEK;
            run_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            wait_q  <= '0;
            lock_q  <= '0;
            tmo_q   <= '0;
            tip_q   <= '0;
            blank_q <= BLANK_TARGET;
            amp_q   <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            hs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            wait_q  <= wait_d;
            lock_q  <= lock_d;
            tmo_q   <= tmo_d;
            tip_q   <= tip_d;
            blank_q <= blank_d;
            amp_q   <= amp_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            hs_q    <= hs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        wait_d  = wait_q;
        lock_d  = lock_q;
        tmo_d   = tmo_q;
        tip_d   = tip_q;
        blank_d = blank_q;
        amp_d   = amp_q;
        dout_d  = dout_q;
        dv_d    = vif.sample_valid;
        hs_d    = 1'b0;

        below     = vif.adc_data < SYNC_LEVEL;
        acc_sum   = acc_q + ACC_W'(vif.adc_data);
        pix       = $signed({2'b00, vif.adc_data}) - $signed({2'b00, blank_q})
                    + $signed({2'b00, BLANK_TARGET});
        avg       = 12'(acc_sum >> BP_LEN_LOG2);
        diff      = $signed({2'b00, avg}) - $signed({2'b00, blank_q});
        new_blank = $signed({2'b00, blank_q}) + (diff >>> IIR_SHIFT);
        amp_diff  = new_blank - $signed({2'b00, tip_q});

        if (vif.sample_valid) begin
            if (pix < 0)
                dout_d = 12'd0;
            else if (pix > 14'sd4095)
                dout_d = 12'd4095;
            else
                dout_d = 12'(pix);

            case (state_q)
                SEEK: begin
                    if (below) begin
                        state_d = TIP;
                        run_d   = RUN_W'(1);
                        acc_d   = ACC_W'(vif.adc_data);
                        cnt_d   = CNT_W'(1);
                    end
                end
                TIP: begin
                    if (below) begin
                        if (run_q <= RUN_MAX)
                            run_d = run_q + 1'b1;
                        if (cnt_q < TIP_N) begin
                            acc_d = acc_sum;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (run_q < RUN_MIN || run_q > RUN_MAX) begin
                        state_d = SEEK;
                    end else begin
                        hs_d    = 1'b1;
                        state_d = WAIT;
                        wait_d  = '0;
                        acc_d   = '0;
                        cnt_d   = '0;
                        if (cnt_q == TIP_N)
                            tip_d = 12'(acc_q >> TIP_LEN_LOG2);
                    end
                end
                WAIT: begin
                    if (wait_q == WAIT_LAST)
                        state_d = PORCH;
                    else
                        wait_d = wait_q + 1'b1;
                end
                PORCH: begin
                    // Sync-level or over-range samples mean the porch is corrupt; drop the line.
                    if (vif.adc_otr || below) begin
                        lock_d  = '0;
                        state_d = SEEK;
                    end else if (cnt_q == BP_LAST) begin
                        blank_d = 12'(new_blank);
                        amp_d   = amp_diff[13] ? 12'd0 : 12'(amp_diff);
                        if (lock_q != LOCK_MAX)
                            lock_d = lock_q + 1'b1;
                        state_d = SEEK;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = SEEK;
            endcase

            // A tip end in the same sample as the timeout keeps the line alive.
            if (hs_d) begin
                tmo_d = '0;
            end else if (tmo_q != TMO_MAX) begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_q == TMO_MAX - 1'b1) begin
                    lock_d  = '0;
                    state_d = SEEK;
                end
            end
        end
    end

    assign vif.data_out     = dout_q;
    assign vif.data_valid   = dv_q;
    assign vif.blank_level  = blank_q;
    assign vif.tip_level    = tip_q;
    assign vif.sync_amp     = amp_q;
    assign vif.clamp_locked = (lock_q == LOCK_MAX);
    assign vif.hsync_seen   = hs_q;
endmodule

// File: tb/tb_video_dc_restore.sv
// tb/tb_video_dc_restore.sv - randomized line stimulus on two clamps (IIR_SHIFT 0 and 2)
// checked every cycle against a sample-level reference model.
module tb_video_dc_restore;
    logic clk;
    logic rst_n;

    video_dc_restore_if if0 ();
    video_dc_restore_if if2 ();

    video_dc_restore #(.IIR_SHIFT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .vif(if0));
    video_dc_restore #(.IIR_SHIFT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .vif(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    int shift_k[2] = '{0, 2};
    int m_blank[2];
    int m_amp[2];
    int exp_data[2];
    int m_tip, m_lock, m_run, m_pos, m_quiet, m_tip_sum, m_tip_n, m_psum;
    bit exp_dv, exp_hs;

    task automatic chk(input string name, input int k, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t got %0d want %0d", name, k, $time, got, want);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_blank[k]  = 1200;
            m_amp[k]    = 0;
            exp_data[k] = 0;
        end
        m_tip = 0; m_lock = 0; m_run = 0; m_pos = -1; m_quiet = 0;
        m_tip_sum = 0; m_tip_n = 0; m_psum = 0;
        exp_dv = 1'b0; exp_hs = 1'b0;
    endtask

    // m_run > 0: inside a tip run; m_pos >= 0: samples since a valid tip ended.
    task automatic model_sample(input int x, input bit otr);
        bit hs = 1'b0;
        for (int k = 0; k < 2; k++) begin
            int v = x - m_blank[k] + 1200;
            exp_data[k] = (v < 0) ? 0 : ((v > 4095) ? 4095 : v);
        end
        if (m_run > 0) begin
            if (x < 1024) begin
                if (m_tip_n < 64) begin
                    m_tip_sum += x;
                    m_tip_n++;
                end
                if (m_run <= 400) m_run++;
            end else begin
                if (m_run >= 100 && m_run <= 400) begin
                    hs = 1'b1;
                    if (m_tip_n == 64) m_tip = m_tip_sum / 64;
                    m_pos  = 0;
                    m_psum = 0;
                end
                m_run = 0;
            end
        end else if (m_pos >= 0) begin
            m_pos++;
            if (m_pos > 20) begin
                if (otr || x < 1024) begin
                    m_lock = 0;
                    m_pos  = -1;
                end else begin
                    m_psum += x;
                    if (m_pos == 20 + 64) begin
                        int avg = m_psum / 64;
                        for (int k = 0; k < 2; k++) begin
                            m_blank[k] += (avg - m_blank[k]) >>> shift_k[k];
                            m_amp[k] = (m_blank[k] > m_tip) ? m_blank[k] - m_tip : 0;
                        end
                        if (m_lock < 8) m_lock++;
                        m_pos = -1;
                    end
                end
            end
        end else if (x < 1024) begin
            m_run = 1; m_tip_sum = x; m_tip_n = 1;
        end
        if (hs) begin
            m_quiet = 0;
        end else if (m_quiet < 4095) begin
            m_quiet++;
            if (m_quiet == 4095) begin
                m_lock = 0; m_run = 0; m_pos = -1;
            end
        end
        exp_dv = 1'b1;
        exp_hs = hs;
    endtask

    task automatic step(input bit v, input int x, input bit o);
        if0.sample_valid = v; if0.adc_data = 12'(x); if0.adc_otr = o;
        if2.sample_valid = v; if2.adc_data = 12'(x); if2.adc_otr = o;
        @(posedge clk);
        if (v) model_sample(x, o);
        else begin
            exp_dv = 1'b0;
            exp_hs = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic put(input int x, input bit o);
        int gaps = ($urandom_range(0, 3) == 0) ? 2 : 1;
        for (int g = 0; g < gaps; g++)
            step(1'b0, int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
        step(1'b1, x, o);
    endtask

    task automatic line(input int tip, input int porch, input int pnoise, input int otr_at);
        for (int i = 0; i < 174; i++) put(tip, 1'b0);
        for (int i = 0; i < 170; i++)
            put(porch + int'($urandom_range(0, 2 * pnoise)) - pnoise, i == otr_at);
        for (int i = 0; i < 256; i++) put(int'($urandom_range(1100, 4095)), 1'b0);
    endtask

    task automatic chk_outs(input int k, input int dout, input int dv, input int bl,
                            input int tl, input int amp, input int lk, input int hs);
        chk("data_valid", k, dv, int'(exp_dv));
        if (exp_dv) chk("data_out", k, dout, exp_data[k]);
        chk("blank_level", k, bl, m_blank[k]);
        chk("tip_level", k, tl, m_tip);
        chk("sync_amp", k, amp, m_amp[k]);
        chk("clamp_locked", k, lk, int'(m_lock == 8));
        chk("hsync_seen", k, hs, int'(exp_hs));
    endtask

    task automatic rst_lits(input int k, input int dout, input int dv, input int bl,
                            input int tl, input int amp, input int lk, input int hs);
        chk("rst_data_out", k, dout, 0);
        chk("rst_data_valid", k, dv, 0);
        chk("rst_blank_level", k, bl, 1200);
        chk("rst_tip_level", k, tl, 0);
        chk("rst_sync_amp", k, amp, 0);
        chk("rst_clamp_locked", k, lk, 0);
        chk("rst_hsync_seen", k, hs, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk_outs(0, if0.data_out, if0.data_valid, if0.blank_level, if0.tip_level,
                     if0.sync_amp, if0.clamp_locked, if0.hsync_seen);
            chk_outs(1, if2.data_out, if2.data_valid, if2.blank_level, if2.tip_level,
                     if2.sync_amp, if2.clamp_locked, if2.hsync_seen);
        end
    end

    task automatic all_rst_lits();
        rst_lits(0, if0.data_out, if0.data_valid, if0.blank_level, if0.tip_level,
                 if0.sync_amp, if0.clamp_locked, if0.hsync_seen);
        rst_lits(1, if2.data_out, if2.data_valid, if2.blank_level, if2.tip_level,
                 if2.sync_amp, if2.clamp_locked, if2.hsync_seen);
    endtask

    initial begin
        rst_n = 1'b0;
        if0.sample_valid = 1'b0; if0.adc_data = 12'd2000; if0.adc_otr = 1'b0;
        if2.sample_valid = 1'b0; if2.adc_data = 12'd2000; if2.adc_otr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        all_rst_lits();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        repeat (20) put(2000, 1'b0);
        chk("lit_out_identity", 0, if0.data_out, 2000);
        chk("lit_out_identity", 1, if2.data_out, 2000);
        chk("lit_valid", 0, if0.data_valid, 1);
        chk("lit_locked", 0, if0.clamp_locked, 0);

        line(500, 1800, 0, -1);
        chk("lit_blank_l1", 0, if0.blank_level, 1800);
        chk("lit_model_blank_l1", 0, m_blank[0], 1800);
        chk("lit_tip_l1", 0, if0.tip_level, 500);
        chk("lit_amp_l1", 0, if0.sync_amp, 1300);
        chk("lit_blank_l1", 1, if2.blank_level, 1350);
        chk("lit_model_blank_l1", 1, m_blank[1], 1350);
        put(2500, 1'b0);
        chk("lit_active_out", 0, if0.data_out, 1900);
        chk("lit_active_out", 1, if2.data_out, 2350);

        line(500, 1800, 0, -1);
        chk("lit_blank_l2", 1, if2.blank_level, 1462);
        chk("lit_model_blank_l2", 1, m_blank[1], 1462);
        for (int l = 3; l <= 7; l++) line(500, 1800, 0, -1);
        chk("lit_locked_l7", 0, if0.clamp_locked, 0);
        line(500, 1800, 0, -1);
        chk("lit_locked_l8", 0, if0.clamp_locked, 1);
        chk("lit_model_locked_l8", 0, m_lock, 8);
        repeat (2) line(500, 1800, 3, -1);

        line(800, 2100, 0, -1);
        chk("lit_step_blank", 0, if0.blank_level, 2100);
        chk("lit_step_amp", 0, if0.sync_amp, 1300);
        chk("lit_step_locked", 1, if2.clamp_locked, 1);
        repeat (3) line(800, 2100, 0, -1);

        repeat (100) put(2000, 1'b0);
        repeat (50) put(500, 1'b0);
        repeat (100) put(2000, 1'b0);
        repeat (1000) put(500, 1'b0);
        repeat (300) put(2000, 1'b0);
        chk("lit_broad_blank", 0, if0.blank_level, 2100);
        chk("lit_broad_tip", 0, if0.tip_level, 800);
        chk("lit_broad_locked", 0, if0.clamp_locked, 1);

        line(800, 2100, 0, 40);
        chk("lit_otr_locked", 0, if0.clamp_locked, 0);
        chk("lit_otr_blank", 0, if0.blank_level, 2100);
        repeat (7) line(800, 2100, 0, -1);
        chk("lit_relock_7", 1, if2.clamp_locked, 0);
        line(800, 2100, 0, -1);
        chk("lit_relock_8", 1, if2.clamp_locked, 1);

        for (int j = 1; j <= 5000; j++) begin
            put(2000, 1'b0);
            if (j == 3669) chk("lit_tmo_before", 0, if0.clamp_locked, 1);
            if (j == 3670) begin
                chk("lit_tmo_drop", 0, if0.clamp_locked, 0);
                chk("lit_tmo_valid", 0, if0.data_valid, 1);
            end
        end

        repeat (174) put(800, 1'b0);
        repeat (60) put(2100, 1'b0);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        all_rst_lits();
        if0.sample_valid = 1'b0;
        if2.sample_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        line(800, 2100, 0, -1);
        chk("lit_post_rst_blank", 0, if0.blank_level, 2100);
        chk("lit_post_rst_locked", 0, if0.clamp_locked, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/video_dc_restore.md
Name: video_dc_restore

Overview:
- Black-level clamp (DC restore) between the AD9226 capture register and sync_separator / color_decoder.
- Finds horizontal sync tips in the raw 12-bit composite stream and averages the back porch each line.
- Shifts every sample so the measured blanking level lands on a fixed target code. This removes AC-coupling drift before sync slicing and chroma decode.

Parameters:
- SYNC_LEVEL, 12'd1024: raw code; samples below it count as sync tip.
- MIN_SYNC, 100: minimum consecutive tip samples for a valid h-sync (about 2.7 us at 37.125 MS/s).
- MAX_SYNC, 400: tip run longer than this is a broad/vertical pulse and gets no measurement.
- TIP_LEN_LOG2, 6: log2 of the number of tip samples averaged.
- BP_DELAY, 20: samples skipped after the sync rising edge before porch accumulation starts.
- BP_LEN_LOG2, 6: log2 of the number of back-porch samples averaged.
- IIR_SHIFT, 2: blank-level filter shift; 0 means direct replacement.
- BLANK_TARGET, 12'd1200: output code that the blanking level is mapped to.
- LOCK_LINES, 8: consecutive good measurements required to assert clamp_locked.
- LINE_TIMEOUT, 4095: samples without a valid sync before lock is dropped.

Ports:
- clk, input, 1: pixel clock (74.25 MHz).
- rst_n, input, 1: asynchronous active-low reset.
- sample_valid, input, 1: new ADC sample strobe (every 2nd clk).
- adc_data, input, 12: raw unsigned ADC code.
- adc_otr, input, 1: ADC out-of-range flag.
- data_out, output, 12: clamped sample.
- data_valid, output, 1: data_out is valid this cycle.
- blank_level, output, 12: current filtered blanking estimate (raw code).
- tip_level, output, 12: last sync-tip average (raw code).
- sync_amp, output, 12: blank_level minus tip_level, floored at 0.
- clamp_locked, output, 1: measurements are stable.
- hsync_seen, output, 1: one-clk pulse when a valid h-sync tip ends.

Behaviour:
- Reset values:
  - data_out = 0, data_valid = 0, tip_level = 0, sync_amp = 0.
  - blank_level = BLANK_TARGET, so the datapath is an identity offset.
  - clamp_locked = 0, hsync_seen = 0.
  - FSM = SEEK; all counters and accumulators = 0.
- Only clk edges with sample_valid = 1 advance the FSM, counters, accumulators and datapath. On every other edge, state holds and data_valid = 0.
- Datapath:
  - Latency is 1 clk: data_valid follows sample_valid by one cycle.
  - Computation is signed 14-bit: adc_data − blank_level + BLANK_TARGET, saturated to [0, 4095].
  - Uses the blank_level value registered before the same edge.
- FSM (evaluated on valid samples):
  - SEEK: if adc_data < SYNC_LEVEL, go to TIP with run = 1, and the tip accumulator and tip count are loaded with this first sample and 1.
  - TIP: while below level, run++ (saturating at MAX_SYNC+1). Tip samples are summed until 2^TIP_LEN_LOG2 have been taken.
    - On the first sample ≥ SYNC_LEVEL:
      - run < MIN_SYNC: noise; go to SEEK, no update.
      - run > MAX_SYNC: vertical interval; go to SEEK, no update, lock unaffected.
      - otherwise: pulse hsync_seen, clear the timeout counter, go to WAIT.
      - tip_level is updated only if 2^TIP_LEN_LOG2 tip samples were taken.
    - When run exceeds MAX_SYNC the FSM stays in TIP until the level rises.
  - WAIT: count BP_DELAY samples, then go to PORCH.
  - PORCH: accumulate 2^BP_LEN_LOG2 samples into an 18-bit accumulator.
    - After the last one: avg = acc >> BP_LEN_LOG2, then blank_level += (avg − blank_level) >>> IIR_SHIFT (arithmetic shift). Update sync_amp and lock_cnt++ (saturating at LOCK_LINES). Go to SEEK.
    - adc_otr = 1 on any porch sample, or a sample below SYNC_LEVEL, aborts the measurement: no update, lock_cnt = 0, go to SEEK.
- Lock:
  - clamp_locked = 1 when lock_cnt == LOCK_LINES.
  - The timeout counter increments on every valid sample and clears on hsync_seen. When it reaches LINE_TIMEOUT: lock_cnt = 0, clamp_locked = 0, FSM forced to SEEK, and the counter saturates until the next hsync_seen.
- Simultaneous events: a timeout in the same sample as a tip end is treated as the tip end (the clear wins).
- Asynchronous reset mid-line returns all outputs to reset values immediately. Operation resumes from SEEK on the first valid sample after release.

Test Plan:
- Reset with data held at 2000 and IIR_SHIFT=0 → data_out = 2000 with data_valid one clk after each sample_valid; clamp_locked = 0.
- Repeating line (tip 500 ×174 samples, porch 1800 ×170, active 2500, 2350 samples/line), IIR_SHIFT=0 → after line 1: blank_level = 1800, tip_level = 500, sync_amp = 1300; porch samples output 1200, active samples output 1900; clamp_locked asserts after line 8.
- Same lines with a +300 DC step at line 20 (porch 2100), IIR_SHIFT=2 → blank_level moves 1800 → 1875 → 1931… toward 2100; lock held throughout.
- 50-sample dip to 500 → no hsync_seen, no blank_level change; 1000-sample broad pulse → no update, clamp_locked stays 1.
- adc_otr pulsed during a porch → that line gives no update and clamp_locked = 0; re-asserts 8 good lines later.
- Constant input 2000 for 5000 samples after lock → clamp_locked drops at sample 4095, data still valid; rst_n pulsed mid-porch → all outputs at reset values asynchronously.
